ling_adder_64: RTL and testbench
================================

# ling_adder_64

Registered 64-bit binary adder built on a Ling parallel-prefix carry network, computing {cout, s} = ain + bin + cin. It is the wide-add datapath primitive for arithmetic blocks that need a low-depth 64-bit adder with registered outputs. Results are synchronous to a single clock and clear on a synchronous reset.

## Interface
- N, 64: operand and sum width. The design is verified only at 64.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ain  input  N  operand A, unsigned.
- bin  input  N  operand B, unsigned.
- cin  input  1  carry-in.
- s    output N  registered sum, bits [N-1:0].
- cout output 1  registered carry-out, the sum's bit N.

## Operation
- Per-bit signals, for i = 0..63:
  - g_i = a_i & b_i (generate).
  - t_i = a_i | b_i (transmit).
  - d_i = a_i ^ b_i (half-sum).
- Ling pseudo-carry recurrence: H_i = g_i | (t_{i-1} & H_{i-1}).
  - Boundary terms: H_{-1} = cin and t_{-1} = 1.
  - Consequence: H_0 = g_0 | cin.
- H is evaluated with a parallel prefix tree of ceil(log2 64) = 6 levels (Kogge-Stone or Sklansky) over (g, t) pairs.
  - Combine operator: (G, T) o (G', T') = (G | T&G', T&T').
  - The tree shifts transmit terms by one bit position, per the Ling formulation.
  - A ripple chain is not acceptable.
- Real carry into bit i: c_i = t_{i-1} & H_{i-1}, with c_0 = cin.
- Sum bit: s_i = d_i ^ c_i.
- Carry-out: cout = t_63 & H_63.
- Arithmetic is unsigned, modulo 2^64. Overflow is reported only through cout. No signed-overflow flag.
- Required result: {cout, s} equals the exact 65-bit value ain + bin + cin for all 2^129 input combinations.

## Timing
- Inputs are sampled on each rising edge of clk. No handshake; a new operand set is accepted every cycle.
- Latency is 1 cycle. s and cout reflect the inputs present at edge k from edge k onward, until edge k+1.
- Throughput is one add per cycle.
- The adder core is combinational. Only the output registers hold state.
- Reset:
  - While rst = 1 at a rising edge, s <= 0 and cout <= 0, regardless of the inputs.
  - Reset takes priority over the computation.
  - Deasserting rst mid-stream causes the first edge with rst = 0 to load the sum of the inputs present at that edge.
- X or Z on an input may propagate to the outputs. No input sanitisation.

## Configuration
- Macro LING_ADDER_INPUT_REG_EN.
- When defined:
  - ain, bin and cin are additionally captured in an input register stage before the Ling core.
  - Latency becomes 2 cycles and throughput stays 1 per cycle.
  - rst also clears the input registers to 0. The first valid result appears on the second edge after rst deasserts.
- When undefined: no input registers, latency 1 cycle, as described above.

## Test plan
- Directed vectors, one cycle latency each:
  - ain=0, bin=0, cin=1 -> s=64'h1, cout=0.
  - ain=64'hFFFF_FFFF_FFFF_FFFF, bin=0, cin=1 -> s=0, cout=1. Full-length carry propagation.
  - ain=64'h8000_0000_0000_0000, bin=64'h8000_0000_0000_0000, cin=0 -> s=0, cout=1.
  - ain=64'hAAAA_AAAA_AAAA_AAAA, bin=64'h5555_5555_5555_5555, cin=1 -> s=0, cout=1. The same operands with cin=0 -> s=64'hFFFF_FFFF_FFFF_FFFF, cout=0.
- Reset:
  - Hold ain=bin=64'hFFFF_FFFF_FFFF_FFFF, cin=1, with rst=1 for 2 cycles -> s=0, cout=0.
  - Release rst -> one edge later s=64'hFFFF_FFFF_FFFF_FFFF, cout=1.
- Random:
  - Apply at least 15 back-to-back random operand sets with random cin, one per cycle.
  - Each result must equal the 65-bit reference sum ain+bin+cin, one cycle later (two with LING_ADDER_INPUT_REG_EN).
  - Any mismatch is an error.

Source files
------------

// File: rtl/ling_adder_64_if.sv
// ling_adder_64_if: operand/result bundle for the registered Ling adder.
//   ain, bin : operands, unsigned, N bits
//   cin      : carry-in
//   s        : registered sum, N bits
//   cout     : registered carry-out (sum bit N)
// Modports: master drives the operands and reads the result; slave is the adder.
interface ling_adder_64_if #(
   parameter int N = 64
);
   logic [N-1:0] ain;
   logic [N-1:0] bin;
   logic         cin;
   logic [N-1:0] s;
   logic         cout;

   modport master (
      output ain, bin, cin,
      input  s, cout
   );

   modport slave (
      input  ain, bin, cin,
      output s, cout
   );
endinterface

// File: rtl/ling_adder_64.sv
// ling_adder_64: registered 64-bit adder, {cout, s} = ain + bin + cin, built on a
// Kogge-Stone prefix tree that evaluates the Ling pseudo-carry H.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset; clears every register
//   bus  : ling_adder_64_if.slave (ain, bin, cin in; s, cout out)
// Build option LING_ADDER_INPUT_REG_EN: adds an input register stage in front of
// the core, making latency 2 cycles instead of 1 (throughput stays 1 per cycle).
module ling_adder_64 (
   input  logic             clk,
   input  logic             rst,
   ling_adder_64_if.slave   bus
);
   localparam int N      = 64;
   localparam int LEVELS = $clog2(N);

   logic [N-1:0] a_core;
   logic [N-1:0] b_core;
   logic         c_core;

`ifdef LING_ADDER_INPUT_REG_EN
   logic [N-1:0] ain_q, ain_d;
   logic [N-1:0] bin_q, bin_d;
   logic         cin_q, cin_d;

   always_comb begin
      ain_d = bus.ain;
      bin_d = bus.bin;
      cin_d = bus.cin;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ain_q <= '0;
         bin_q <= '0;
         cin_q <= 1'b0;
      end else begin
         ain_q <= ain_d;
         bin_q <= bin_d;
         cin_q <= cin_d;
      end
   end

   assign a_core = ain_q;
   assign b_core = bin_q;
   assign c_core = cin_q;
`else
   assign a_core = bus.ain;
   assign b_core = bus.bin;
   assign c_core = bus.cin;
`endif

   // Kogge-Stone prefix over (G, T) pairs. Each loop pass is one tree level:
   // every bit combines with the bit 2^lvl below it in parallel. Bits closer
   // to the bottom than the span keep their value (shifted-in zeros for G,
   // a ones mask for T).
   function automatic logic [N-1:0] ling_prefix(input logic [N-1:0] g_in,
                                                input logic [N-1:0] t_in);
      logic [N-1:0] g_v;
      logic [N-1:0] t_v;
      logic [N-1:0] one_v;
      logic [N-1:0] low_mask;
      g_v   = g_in;
      t_v   = t_in;
      one_v = {{(N-1){1'b0}}, 1'b1};
      for (int lvl = 0; lvl < LEVELS; lvl++) begin
         low_mask = (one_v << (1 << lvl)) - one_v;
         g_v      = g_v | (t_v & (g_v << (1 << lvl)));
         t_v      = t_v & ((t_v << (1 << lvl)) | low_mask);
      end
      return g_v;
   endfunction

   logic [N-1:0] g_bit, t_bit, d_bit;
   logic [N-1:0] g_lead, t_shift;
   logic [N-1:0] h_ling;
   logic [N-1:0] carry;

   logic [N-1:0] s_q, s_d;
   logic         cout_q, cout_d;

   always_comb begin
      g_bit   = a_core & b_core;
      t_bit   = a_core | b_core;
      d_bit   = a_core ^ b_core;
      // Ling pairs use the transmit of the bit below. cin is folded into bit 0
      // (H_0 = g_0 | cin), so bit 0 needs no transmit term.
      g_lead  = {g_bit[N-1:1], g_bit[0] | c_core};
      t_shift = {t_bit[N-2:0], 1'b0};
      h_ling  = ling_prefix(g_lead, t_shift);
      // Real carry recovered from the pseudo-carry: c_i = t_{i-1} & H_{i-1}.
      carry   = {t_bit[N-2:0] & h_ling[N-2:0], c_core};
      s_d     = d_bit ^ carry;
      cout_d  = t_bit[N-1] & h_ling[N-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign bus.s    = s_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_ling_adder_64.sv
module tb_ling_adder_64;
`ifdef LING_ADDER_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ling_adder_64_if #(.N(64)) bus ();

   ling_adder_64 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Reference: each edge either clears or captures the exact 65-bit sum of
   // the values sitting at the (optional) input stage.
   logic [64:0] exp_out;
   logic [63:0] m_a, m_b;
   logic        m_c;
   logic        exp_valid = 1'b0;

   always @(posedge clk) begin
      if (LAT == 2) begin
         exp_out <= rst ? 65'd0 : ({1'b0, m_a} + {1'b0, m_b} + {64'd0, m_c});
         m_a     <= rst ? 64'd0 : bus.ain;
         m_b     <= rst ? 64'd0 : bus.bin;
         m_c     <= rst ? 1'b0  : bus.cin;
      end else begin
         exp_out <= rst ? 65'd0 : ({1'b0, bus.ain} + {1'b0, bus.bin} + {64'd0, bus.cin});
      end
      exp_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (exp_valid) begin
         checks++;
         if ({bus.cout, bus.s} !== exp_out) begin
            failures++;
            $display("FAIL model_cmp t=%0t got cout=%b s=%h want cout=%b s=%h",
                     $time, bus.cout, bus.s, exp_out[64], exp_out[63:0]);
         end
      end
   end

   task automatic check_lit(input string name, input logic [63:0] es, input logic ec);
      checks++;
      if (bus.s !== es || bus.cout !== ec) begin
         failures++;
         $display("FAIL %s got cout=%b s=%h want cout=%b s=%h",
                  name, bus.cout, bus.s, ec, es);
      end
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic c);
      @(negedge clk);
      bus.ain = a;
      bus.bin = b;
      bus.cin = c;
   endtask

   task automatic run_vec(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic [63:0] es, input logic ec);
      drive(a, b, c);
      repeat (LAT) @(posedge clk);
      #1;
      check_lit(name, es, ec);
   endtask

   initial begin
      rst     = 1'b1;
      bus.ain = 64'd0;
      bus.bin = 64'd0;
      bus.cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_lit("reset_state", 64'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      run_vec("zero_plus_cin", 64'd0, 64'd0, 1'b1, 64'h1, 1'b0);
      run_vec("full_propagate", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1);
      run_vec("msb_overflow", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
              64'd0, 1'b1);
      run_vec("alt_cin1", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1,
              64'd0, 1'b1);
      run_vec("alt_cin0", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      run_vec("mid_carry", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
              64'h0000_0001_0000_0000, 1'b0);

      // Reset dominates all-ones inputs, then release loads their sum.
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_lit("reset_hold", 64'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT) @(posedge clk);
      #1;
      check_lit("reset_release", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

      // Back-to-back random operands; the per-cycle compare checks each result.
      for (int i = 0; i < 24; i++) begin
         drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 8; i++) begin
         logic [63:0] ra;
         ra = {$urandom, $urandom};
         drive(ra, ~ra, 1'($urandom_range(0, 1)));
      end
      repeat (LAT + 2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
